serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial add/subtract engine: sequences ONE full_adder_1bit over WIDTH cycles
//   to add or subtract two WIDTH-bit operands, trading area for latency.
//   Sits beside the ripple adders as the low-area arithmetic option.
//   Operands enter on a valid/ready request port; results leave on a valid/ready
//   response port.
// PARAMETERS
//   WIDTH   32   operand/result width in bits; legal range >= 2
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   req_valid   in   1      operands and mode presented
//   req_ready   out  1      block accepts a request (IDLE only)
//   op_a        in   WIDTH  operand A
//   op_b        in   WIDTH  operand B
//   cin_in      in   1      carry-in for add; ignored when sub=1
//   sub         in   1      0: A+B+cin_in, 1: A-B (A + ~B + 1)
//   rsp_valid   out  1      result, cout and overflow valid
//   rsp_ready   in   1      consumer takes the response
//   result      out  WIDTH  sum/difference
//   cout        out  1      final carry out (sub: 1 = no borrow)
//   overflow    out  1      signed overflow = carry into MSB ^ carry out of MSB
//   busy        out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; req_ready=1; rsp_valid=0; busy=0;
//     result=0; cout=0; overflow=0; shift regs, carry reg and bit counter cleared.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: req_ready=1. On req_valid&req_ready: load a_sh=op_a,
//     b_sh=sub?~op_b:op_b, carry=sub?1:cin_in, cnt=0 -> RUN.
//   RUN: each cycle, FA(a_sh[0], b_sh[0], carry) -> sum bit shifted into
//     result MSB (result shifts right), carry<=FA cout, a_sh/b_sh shift right,
//     cnt++. On cnt==WIDTH-2, latch current carry as msb_cin.
//     On cnt==WIDTH-1 -> DONE; cout<=FA cout; overflow<=msb_cin^FA cout.
//   DONE: rsp_valid=1; result/cout/overflow held stable until rsp_valid&rsp_ready,
//     then -> IDLE in the next cycle. No back-to-back overlap.
//   Latency: accept edge + WIDTH RUN cycles; rsp_valid high on the first cycle
//     after the last bit (cycle WIDTH+1 counting accept as cycle 0).
//   req_valid while not IDLE: ignored (req_ready=0); operands never corrupted.
//   rsp_ready while not DONE: ignored.
//   result is not valid outside DONE; rsp_valid is the only qualifier.
//   rst asserted mid-RUN or mid-DONE: aborts, no response issued, back to IDLE.
//   Width rules: arithmetic modulo 2^WIDTH; cnt width = $clog2(WIDTH).
// STRUCTURE
//   Shared package: state encoding typedef (IDLE/RUN/DONE) and SA_CNT_W helper.
//   One sub-module instance: full_adder_1bit (existing, built from two half_adder)
//   as the sole arithmetic datapath; FSM, counter and shift regs in this module.
// TESTING (WIDTH=32)
//   0xFFFFFFFF+0x00000001, cin=0 -> result=0, cout=1, overflow=0, rsp_valid
//     exactly 33 cycles after the accept edge.
//   0x7FFFFFFF+0x00000001 -> result=0x80000000, cout=0, overflow=1.
//   sub=1, 5-7 -> result=0xFFFFFFFE, cout=0, overflow=0; 7-5 -> 2, cout=1.
//   Hold rsp_ready=0 for 10 cycles in DONE -> outputs stable, req_ready=0,
//     a req_valid pulse is not accepted; rsp_ready=1 -> IDLE next cycle.
//   Assert rst at RUN bit 10 -> all outputs at reset values without a clock
//     edge; next request 3+4 completes with result=7 and no stale response.
//   1000 random add/sub ops with random rsp_ready stalls vs behavioural model.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract engine: state encoding
// and the bit-counter width helper.
package serial_adder_ctrl_pkg;

    typedef logic [1:0] sa_state_t;

    localparam sa_state_t ST_IDLE = 2'd0;
    localparam sa_state_t ST_RUN  = 2'd1;
    localparam sa_state_t ST_DONE = 2'd2;

    function automatic int sa_cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder composed of two half adders; the only arithmetic
// element of the serial engine.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
    half_adder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

    assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder, building block of full_adder_1bit.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full adder is stepped over WIDTH cycles,
// LSB first, with valid/ready handshakes on the request and response sides.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_in,
    input  logic             sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int CNT_W = sa_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MSB_M1 = CNT_W'(WIDTH - 2);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);

    sa_state_t        state_q,   state_d;
    logic [WIDTH-1:0] a_sh_q,    a_sh_d;
    logic [WIDTH-1:0] b_sh_q,    b_sh_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             carry_q,   carry_d;
    logic             msb_cin_q, msb_cin_d;
    logic             cout_q,    cout_d;
    logic             ovf_q,     ovf_d;

    logic fa_sum;
    logic fa_cout;

    full_adder_1bit u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_sh_d  = op_a;
                    b_sh_d  = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                result_d = {fa_sum, result_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                // carry produced by bit WIDTH-2 is the carry into the MSB
                if (cnt_q == CNT_MSB_M1) begin
                    msb_cin_d = fa_cout;
                end
                if (cnt_q == CNT_LAST) begin
                    cout_d  = fa_cout;
                    ovf_d   = msb_cin_q ^ fa_cout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=32): directed corner cases,
// hold/abort scenarios and randomized traffic against an arithmetic model.
module tb_serial_adder_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin_in = 1'b0;
    logic         sub = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin_in    (cin_in),
        .sub       (sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain two's-complement arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic s, output logic [W-1:0] res, output logic co,
                         output logic ov);
        logic [W:0] full;
        if (s) begin
            res = a - b;
            co  = (a >= b);
            ov  = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            res  = full[W-1:0];
            co   = full[W];
            ov   = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic s, input int stall, input bit noise, input bit hold_chk);
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
        int           waitc;
        int           lat;
        model(a, b, ci, s, er, ec, eo);
        op_a = a; op_b = b; cin_in = ci; sub = s;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        waitc = 0;
        while (!req_ready && waitc < 100) begin
            tick();
            waitc++;
        end
        chk("req_ready_idle", req_ready, 1);
        tick();
        // operands and handshakes wiggle during RUN; all must be ignored
        req_valid = noise ? 1'($urandom) : 1'b0;
        rsp_ready = noise ? 1'($urandom) : 1'b0;
        op_a = $urandom; op_b = $urandom; cin_in = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            tick();
            lat++;
            if (noise) begin
                req_valid = 1'($urandom);
                rsp_ready = 1'($urandom);
                op_a = $urandom; op_b = $urandom;
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        // accept cycle is cycle 0, so the response shows in cycle W+1
        chk("latency_cycle", lat + 1, W + 1);
        for (int i = 0; i < stall; i++) begin
            if (hold_chk && i == 4) begin
                req_valid = 1'b1;
                op_a = ~a; op_b = ~b;
            end
            tick();
            req_valid = 1'b0;
            if (hold_chk) begin
                chk("hold_result", result, er);
                chk("hold_cout", cout, ec);
                chk("hold_ovf", overflow, eo);
                chk("hold_rsp_valid", rsp_valid, 1);
                chk("hold_req_ready", req_ready, 0);
            end
        end
        chk("result", result, er);
        chk("cout", cout, ec);
        chk("overflow", overflow, eo);
        chk("rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("idle_after_rsp", {rsp_valid, busy, req_ready}, 3'b001);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sel;

        repeat (3) tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_cout_ovf", {cout, overflow}, 0);
        rst = 1'b0;
        tick();

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        run_op(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0, 1'b0);

        // long hold in DONE with a stray request pulse
        run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 10, 1'b0, 1'b1);
        tick();
        chk("stray_req_not_accepted", busy, 0);

        // abort mid-RUN with an asynchronous reset
        op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D; cin_in = 1'b1; sub = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("abort_req_ready", req_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_cout_ovf", {cout, overflow}, 0);
        tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("no_stale_rsp", rsp_valid, 0);
        end
        run_op(32'd3, 32'd4, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            sel = $urandom_range(0, 9);
            ra = (sel == 0) ? 32'h7FFF_FFFF : (sel == 1) ? 32'h8000_0000 : $urandom;
            rb = (sel == 2) ? 32'hFFFF_FFFF : (sel == 3) ? ra : $urandom;
            run_op(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
